// File: rtl/bin2bcd.sv
// Sequential 11-bit binary to packed 13-bit BCD converter (double-dabble, one bit per clock).
// Optional saturation of inputs above 1999 is enabled by defining BIN2BCD_SAT_EN.
module bin2bcd (
  input  logic        clk,
  input  logic        reset,
  input  logic        start,
  input  logic [10:0] bin,
  output logic        ready,
  output logic        done_tick,
  output logic [12:0] bcd,
  output logic        ovf
);

  localparam int unsigned BIN_W = 11;
  localparam int unsigned DIG_W = 4;
  localparam int unsigned BCD_W = 13;
  localparam int unsigned CNT_W = 4;
  localparam int unsigned SR_W  = 4 * DIG_W + BIN_W;
  localparam logic [CNT_W-1:0] N_SHIFT = CNT_W'(BIN_W);
  localparam logic [BIN_W-1:0] MAX_DISP = BIN_W'(1999);
  localparam logic [BCD_W-1:0] SAT_BCD = 13'h1999;

  typedef enum logic [1:0] {IDLE, OP, DONE} state_t;

  state_t            state, state_nxt;
  logic [BIN_W-1:0]  sh, sh_nxt;
  logic [DIG_W-1:0]  thou, hun, ten, one;
  logic [DIG_W-1:0]  thou_nxt, hun_nxt, ten_nxt, one_nxt;
  logic [CNT_W-1:0]  cnt, cnt_nxt;
  logic [BCD_W-1:0]  bcd_nxt;
  logic [SR_W-1:0]   shifted;

  function automatic logic [DIG_W-1:0] add3(input logic [DIG_W-1:0] d);
    return (d >= DIG_W'(5)) ? d + DIG_W'(3) : d;
  endfunction

  // Adjust every digit, then shift digits and binary left as one register.
  assign shifted = {add3(thou), add3(hun), add3(ten), add3(one), sh} << 1;

  assign ready     = (state == IDLE);
  assign done_tick = (state == DONE);

`ifdef BIN2BCD_SAT_EN
  logic big, big_nxt;
  logic ovf_q, ovf_nxt;
  assign ovf = ovf_q;
`else
  assign ovf = 1'b0;
`endif

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state <= IDLE;
      sh    <= '0;
      thou  <= '0;
      hun   <= '0;
      ten   <= '0;
      one   <= '0;
      cnt   <= '0;
      bcd   <= '0;
`ifdef BIN2BCD_SAT_EN
      big   <= 1'b0;
      ovf_q <= 1'b0;
`endif
    end else begin
      state <= state_nxt;
      sh    <= sh_nxt;
      thou  <= thou_nxt;
      hun   <= hun_nxt;
      ten   <= ten_nxt;
      one   <= one_nxt;
      cnt   <= cnt_nxt;
      bcd   <= bcd_nxt;
`ifdef BIN2BCD_SAT_EN
      big   <= big_nxt;
      ovf_q <= ovf_nxt;
`endif
    end
  end

  always_comb begin
    state_nxt = state;
    sh_nxt    = sh;
    thou_nxt  = thou;
    hun_nxt   = hun;
    ten_nxt   = ten;
    one_nxt   = one;
    cnt_nxt   = cnt;
    bcd_nxt   = bcd;
`ifdef BIN2BCD_SAT_EN
    big_nxt   = big;
    ovf_nxt   = ovf_q;
`endif
    case (state)
      IDLE: begin
        if (start) begin
          sh_nxt    = bin;
          thou_nxt  = '0;
          hun_nxt   = '0;
          ten_nxt   = '0;
          one_nxt   = '0;
          cnt_nxt   = N_SHIFT;
`ifdef BIN2BCD_SAT_EN
          big_nxt   = (bin > MAX_DISP);
`endif
          state_nxt = OP;
        end
      end
      OP: begin
        {thou_nxt, hun_nxt, ten_nxt, one_nxt, sh_nxt} = shifted;
        cnt_nxt = cnt - CNT_W'(1);
        if (cnt == CNT_W'(1)) begin
          // Only thousands[0] is displayable; 2000..2047 wrap unless saturated.
          bcd_nxt   = {shifted[BIN_W + 3*DIG_W], shifted[BIN_W +: 3*DIG_W]};
`ifdef BIN2BCD_SAT_EN
          ovf_nxt   = big;
          if (big) bcd_nxt = SAT_BCD;
`endif
          state_nxt = DONE;
        end
      end
      DONE:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

endmodule

// File: doc/bin2bcd.md
# bin2bcd

Sequential binary-to-BCD converter that produces the packed 13-bit decimal word and the one-cycle `done_tick` consumed by the seven-segment display driver in the Babbage engine datapath. It accepts an 11-bit unsigned result from the difference-engine FSMD on a `start` strobe. It converts the value with a shift-and-add-3 (double-dabble) state machine, one bit per clock. It then presents four digits packed as {thousands[0], hundreds, tens, ones} together with a single-cycle completion pulse.

## Interface
- Parameters: none. Input width is fixed at 11 bits, matching the 13-bit packed output (maximum displayable value 1999).
- `clk` input 1: single system clock; all state changes on its rising edge.
- `reset` input 1: asynchronous, active-high; clears all state immediately.
- `start` input 1: conversion request; sampled only while `ready`=1.
- `bin` input 11: unsigned binary value; captured on the accepting edge.
- `ready` output 1: high in IDLE; block can accept `start`.
- `done_tick` output 1: one-cycle pulse; `bcd` holds the new result in the same cycle.
- `bcd` output 13: packed result; [3:0] ones, [7:4] tens, [11:8] hundreds, [12] thousands. Held until the next `done_tick`.
- `ovf` output 1: input exceeded 1999; see Configuration. Valid with `bcd`.

## Operation
- States: IDLE, OP, DONE. Reset state is IDLE.
- Reset values: `ready`=1, `done_tick`=0, `bcd`=13'h0000, `ovf`=0, shift/digit registers=0, bit counter=0.
- **IDLE**:
  - `ready`=1.
  - On `start`=1, load the binary shift register with `bin`, clear four 4-bit digit registers (thousands is internally 4 bits), load the counter with 11, and go to OP.
  - With `start`=0, stay in IDLE.
- **OP**, each cycle:
  - Every digit register ≥5 gets +3 (combinational adjust).
  - The adjusted {thou, hun, ten, one, bin} is shifted left one bit as a unit.
  - Counter decrements.
  - When the counter reaches 1 on this edge (the 11th shift), go to DONE and register the packed result into `bcd`/`ovf`.
- **DONE**: `done_tick`=1 for exactly this cycle, then unconditionally to IDLE.
- `start` outside IDLE is ignored. It is not queued, and `bin` changes while busy have no effect.
- Digit arithmetic: each adjusted digit stays within 4 bits (max 4'd9 after the final shift). Internal thousands reaches at most 2 (for 2047).
- Reset mid-operation aborts the conversion. The block returns to IDLE with `bcd` cleared, no `done_tick`, and no partial result visible.

## Timing
- Start accepted at edge E0 (`ready`=1, `start`=1) → `ready` low from E0.
- Shifts occur at E1..E11; state is DONE after E11.
- `done_tick` is high between E11 and E12. `bcd`/`ovf` are updated at E11.
- IDLE and `ready`=1 after E12. Next `start` can be accepted at E12, giving a throughput of 1 conversion per 12 cycles.
- Latency: 11 cycles from the accepting edge to the `done_tick` rising edge.
- `done_tick` is never high for two consecutive cycles.
- All outputs are registered or decoded from state; no combinational path from inputs to outputs.

## Configuration
- Macro `BIN2BCD_SAT_EN`.
- **Defined**:
  - If the captured `bin` > 1999, the DONE result is forced to 13'h1999 and `ovf`=1.
  - Otherwise the result is the exact conversion and `ovf`=0.
- **Undefined**:
  - `bcd` takes internal thousands[0] only, so values 2000..2047 wrap to 0000..0047 (thousands bit = 0).
  - `ovf` is tied to 0.
- Comparison against 1999 uses the value captured at E0, not the live `bin`.

## Test plan
- Reset, then `bin`=0, `start` pulse → `done_tick` exactly 11 cycles after accept; `bcd`=13'h0000, `ovf`=0, `ready` back at +12.
- `bin`=1234 → `bcd`=13'h1234; `bin`=1999 → `bcd`=13'h1999; `bin`=7 → `bcd`=13'h0007.
- `bin`=2047:
  - with `BIN2BCD_SAT_EN`: `bcd`=13'h1999, `ovf`=1;
  - without: `bcd`=13'h0047, `ovf`=0.
- `start`=1 held continuously with `bin` changing every cycle → one conversion per 12 cycles. Each result matches the `bin` sampled on its accept edge, and no `done_tick` is produced for the ignored starts.
- Assert `reset` asynchronously 5 cycles into a conversion of 999 → outputs immediately `ready`=1, `bcd`=0, `done_tick`=0; no `done_tick` follows; a new `start` with 42 yields `bcd`=13'h0042.
- Back-to-back: `start` asserted exactly at the cycle `ready` returns → second `done_tick` 12 cycles after the first; `bcd` holds the first result in between.
